// File: rtl/seq_pkg.sv
// Shared types for the sequence player: FSM state encoding, colour codes, width helper.
// Pure definitions, no logic; no flow control.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

  localparam logic [1:0] COL_RED    = 2'b00;
  localparam logic [1:0] COL_GREEN  = 2'b01;
  localparam logic [1:0] COL_BLUE   = 2'b10;
  localparam logic [1:0] COL_YELLOW = 2'b11;

  // ceil(log2(n)), never below 1 so single-entry counters still get a bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter that saturates at zero; expired is high while the count is zero.
// Load takes effect on the next edge; no backpressure.
module seq_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/seq_player.sv
// Simon-Says playback: start snapshots sequence/round, first colour lit the cycle after acceptance,
// start ignored while busy, abort wins over everything. SEQ_SPEEDUP_EN shortens hold per round.
module seq_player
  import seq_pkg::*;
#(
  parameter int  COLOUR_W        = 2,
  parameter int  MAX_LEN         = 16,
  parameter int  HOLD_CYCLES     = 5_000_000,
  parameter int  GAP_CYCLES      = 1_000_000,
  parameter int  SPEEDUP_STEP    = 250_000,
  parameter int  MIN_HOLD_CYCLES = 1_000_000,
  localparam int LEN_W           = clog2_min1(MAX_LEN)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [MAX_LEN*COLOUR_W-1:0] seq_in,
  input  logic [LEN_W-1:0]            round_ctr,
  output logic [COLOUR_W-1:0]         colour_bus,
  output logic                        colour_oe,
  output logic [LEN_W-1:0]            step_idx,
  output logic                        busy,
  output logic                        complete
);

  localparam int TMR_W    = clog2_min1(((HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES) + 1);
  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  if (HOLD_CYCLES < 1 || GAP_CYCLES < 0 || SPEEDUP_STEP < 0 || MIN_HOLD_CYCLES < 1) begin : g_bad_cfg
    $error("seq_player: invalid timing parameters");
  end

  seq_state_t                  state;
  logic [MAX_LEN*COLOUR_W-1:0] seq_q;
  logic [LEN_W-1:0]            last_q;
  logic [LEN_W-1:0]            last_new;
  logic [LEN_W-1:0]            next_idx;
  logic                        accept;
  logic                        tmr_load;
  logic [TMR_W-1:0]            tmr_val;
  logic                        tmr_expired;
  logic [TMR_W-1:0]            start_hold_m1;
  logic [TMR_W-1:0]            run_hold_m1;

  function automatic logic [COLOUR_W-1:0] colour_at(input logic [MAX_LEN*COLOUR_W-1:0] s,
                                                    input logic [LEN_W-1:0] k);
    return s[k*COLOUR_W +: COLOUR_W];
  endfunction

  assign last_new = (int'(round_ctr) > MAX_LEN - 1) ? LEN_W'(MAX_LEN - 1) : round_ctr;
  assign next_idx = step_idx + 1'b1;
  assign accept   = (state == ST_IDLE) && start && !abort;

`ifdef SEQ_SPEEDUP_EN
  logic [TMR_W-1:0] hold_q;
  logic [TMR_W-1:0] start_hold;

  // Wide signed arithmetic so a large round never wraps the hold below the floor.
  function automatic logic [TMR_W-1:0] speedup_hold(input logic [LEN_W-1:0] last);
    longint red;
    longint h;
    red = longint'(last) * longint'(SPEEDUP_STEP);
    h   = (red >= longint'(HOLD_CYCLES)) ? 64'sd0 : longint'(HOLD_CYCLES) - red;
    if (h < longint'(MIN_HOLD_CYCLES)) h = longint'(MIN_HOLD_CYCLES);
    return TMR_W'(h);
  endfunction

  assign start_hold = speedup_hold(last_new);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (accept) begin
      hold_q <= start_hold;
    end
  end

  assign start_hold_m1 = start_hold - 1'b1;
  assign run_hold_m1   = hold_q - 1'b1;
`else
  assign start_hold_m1 = TMR_W'(HOLD_CYCLES - 1);
  assign run_hold_m1   = TMR_W'(HOLD_CYCLES - 1);
`endif

  // Timer holds count-1 so a phase of N cycles ends on the cycle the count reads zero.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = start_hold_m1;
    case (state)
      ST_IDLE: tmr_load = accept;
      ST_SHOW: begin
        if (tmr_expired && step_idx != last_q) begin
          tmr_load = 1'b1;
          tmr_val  = (GAP_CYCLES > 0) ? TMR_W'(GAP_LOAD) : run_hold_m1;
        end
      end
      ST_GAP: begin
        if (tmr_expired) begin
          tmr_load = 1'b1;
          tmr_val  = run_hold_m1;
        end
      end
      default: ;
    endcase
  end

  seq_timer #(.W(TMR_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .value   (tmr_val),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      seq_q      <= '0;
      last_q     <= '0;
      colour_bus <= '0;
      colour_oe  <= 1'b0;
      step_idx   <= '0;
      busy       <= 1'b0;
      complete   <= 1'b0;
    end else begin
      complete <= 1'b0;
      if (abort) begin
        state      <= ST_IDLE;
        colour_bus <= '0;
        colour_oe  <= 1'b0;
        step_idx   <= '0;
        busy       <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              seq_q      <= seq_in;
              last_q     <= last_new;
              state      <= ST_SHOW;
              colour_bus <= colour_at(seq_in, '0);
              colour_oe  <= 1'b1;
              step_idx   <= '0;
              busy       <= 1'b1;
            end
          end
          ST_SHOW: begin
            if (tmr_expired) begin
              if (step_idx == last_q) begin
                state      <= ST_DONE;
                colour_bus <= '0;
                colour_oe  <= 1'b0;
                complete   <= 1'b1;
              end else if (GAP_CYCLES > 0) begin
                // During the gap step_idx already names the colour about to be shown.
                state      <= ST_GAP;
                colour_bus <= '0;
                colour_oe  <= 1'b0;
                step_idx   <= next_idx;
              end else begin
                colour_bus <= colour_at(seq_q, next_idx);
                step_idx   <= next_idx;
              end
            end
          end
          ST_GAP: begin
            if (tmr_expired) begin
              state      <= ST_SHOW;
              colour_bus <= colour_at(seq_q, step_idx);
              colour_oe  <= 1'b1;
            end
          end
          default: begin
            state    <= ST_IDLE;
            step_idx <= '0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
